sha_pad_stream: RTL

//  Streaming SHA message padder/blocker for SHA-256 (NW=32) and SHA-512 (NW=64).

---
 rtl/sha_pad_stream.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sha_pad_stream.sv
// Streaming SHA-256/512 message padder: appends 0x80, zero fill and the bit-length field,
// then emits 16*NW-bit blocks. Optional abort input when SHA_PAD_ABORT_EN is defined.
module sha_pad_stream #(
  parameter int NW    = 32,
  parameter int LEN_W = 64
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SHA_PAD_ABORT_EN
  input  logic            abort,
`endif
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  input  logic            in_keep,
  input  logic            in_last,
  output logic            in_ready,
  output logic            blk_valid,
  output logic [16*NW-1:0] blk_data,
  output logic            blk_first,
  output logic            blk_last,
  input  logic            blk_ready
);

  localparam int BB    = 2 * NW;
  localparam int LB    = NW / 4;
  localparam int BW    = 16 * NW;
  localparam int LBITS = 8 * LB;
  localparam int PW    = $clog2(BB + 1);

  typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, OUT} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    pos, pos_n;
  logic [LEN_W-1:0] count, count_n;
  logic [BW-1:0]    data_n;
  logic             first_n, last_n;
  logic             first_pend, first_pend_n;
  logic             pad_pend, pad_pend_n;
  logic             sent80, sent80_n;
  logic             beat, wr_en;
  logic [7:0]       wr_byte;
  logic [PW+2:0]    wr_shift;

  assign in_ready  = rst && (state == IDLE || state == FILL);
  assign blk_valid = rst && (state == OUT);
  assign beat      = in_valid && (state == IDLE || state == FILL);
  assign wr_shift  = {PW'(BB - 1) - pos, 3'b000};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pos        <= '0;
      count      <= '0;
      blk_data   <= '0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
      first_pend <= 1'b0;
      pad_pend   <= 1'b0;
      sent80     <= 1'b0;
    end else begin
      state      <= state_n;
      pos        <= pos_n;
      count      <= count_n;
      blk_data   <= data_n;
      blk_first  <= first_n;
      blk_last   <= last_n;
      first_pend <= first_pend_n;
      pad_pend   <= pad_pend_n;
      sent80     <= sent80_n;
    end
  end

  always_comb begin
    state_n      = state;
    pos_n        = pos;
    count_n      = count;
    data_n       = blk_data;
    first_n      = blk_first;
    last_n       = blk_last;
    first_pend_n = first_pend;
    pad_pend_n   = pad_pend;
    sent80_n     = sent80;
    wr_en        = 1'b0;
    wr_byte      = 8'h00;

    case (state)
      IDLE, FILL: begin
        if (beat) begin
          if (state == IDLE) first_pend_n = 1'b1;
          if (in_keep) begin
            wr_en   = 1'b1;
            wr_byte = in_data;
            pos_n   = pos + PW'(1);
            count_n = count + LEN_W'(8);
          end
          if (in_last) begin
            pad_pend_n = 1'b1;
            sent80_n   = 1'b0;
          end
          // A full block always goes out first; padding resumes at pos 0 afterwards.
          if (pos_n == PW'(BB)) begin
            state_n = OUT;
            last_n  = 1'b0;
            first_n = first_pend_n;
          end else if (in_last) begin
            state_n = PAD;
          end else begin
            state_n = FILL;
          end
        end
      end
      PAD: begin
        wr_en    = 1'b1;
        wr_byte  = sent80 ? 8'h00 : 8'h80;
        sent80_n = 1'b1;
        pos_n    = pos + PW'(1);
        if (pos_n == PW'(BB - LB)) begin
          state_n = LEN;
        end else if (pos_n == PW'(BB)) begin
          state_n = OUT;
          last_n  = 1'b0;
          first_n = first_pend;
        end
      end
      LEN: begin
        data_n     = blk_data | BW'(LBITS'(count));
        pad_pend_n = 1'b0;
        state_n    = OUT;
        last_n     = 1'b1;
        first_n    = first_pend;
      end
      OUT: begin
        if (blk_ready) begin
          pos_n        = '0;
          data_n       = '0;
          first_n      = 1'b0;
          last_n       = 1'b0;
          first_pend_n = 1'b0;
          if (blk_last) begin
            state_n = IDLE;
            count_n = '0;
          end else if (pad_pend) begin
            state_n = PAD;
          end else begin
            state_n = FILL;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Byte slots are written once per block into a cleared register, so OR-in is sufficient.
    if (wr_en) data_n = data_n | (BW'(wr_byte) << wr_shift);

`ifdef SHA_PAD_ABORT_EN
    if (abort) begin
      state_n      = IDLE;
      pos_n        = '0;
      count_n      = '0;
      data_n       = '0;
      first_n      = 1'b0;
      last_n       = 1'b0;
      first_pend_n = 1'b0;
      pad_pend_n   = 1'b0;
      sent80_n     = 1'b0;
    end
`endif
  end

endmodule
